multi_operand_summer: RTL and testbench

Parametrised, handshaked, sequential summer. It accepts a vector of NUM_IN operands of WIDTH bits each and adds them one operand per clock into a registered accumulator. It returns the wrapped sum together with a sticky overflow flag, which can be evaluated as either unsigned or signed. It is the next generation of the fixed eight-input 32-bit adder and sits between the register-file read side and its consumers, so the datapath no longer needs a wide combinational adder tree.

---
 rtl/multi_operand_summer.sv | 187 ++++++++++++++++++
 tb/tb_multi_operand_summer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_operand_summer.sv
// -----------------------------------------------------------------------------
// multi_operand_summer
//
// Sequential multi-operand adder with a ready/valid handshake on both sides.
// A vector of NUM_IN operands is captured in one accept cycle. The operands are
// then added into a WIDTH-bit accumulator one per clock, in index order. The
// result is the sum modulo 2^WIDTH plus an overflow flag. The flag is sticky for
// the whole transaction. The in_signed bit, sampled at accept, selects whether
// overflow is judged as unsigned (carry out) or as two's-complement.
//
// Parameters
//   WIDTH      operand and sum width in bits (>= 2)
//   NUM_IN     operands per transaction (>= 2)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operand vector present on in_data/in_signed
//   in_ready   block is idle and can accept a vector
//   in_data    operand i at bits [i*WIDTH +: WIDTH]
//   in_signed  overflow mode for this transaction (1 = signed, 0 = unsigned)
//   out_valid  sum/ovf hold a finished result
//   out_ready  consumer takes the result
//   sum        accumulator (partial sums are visible while accumulating)
//   ovf        sticky overflow of the current/last transaction
// -----------------------------------------------------------------------------
module multi_operand_summer #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_IN*WIDTH-1:0]  in_data,
    input  logic                     in_signed,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         sum,
    output logic                     ovf
);

    localparam int IDX_W = $clog2(NUM_IN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] ops [NUM_IN];
    logic             mode_signed;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] acc;
    logic             acc_ovf;

    logic             accept;
    logic             consume;
    logic             last_step;

    logic [WIDTH-1:0] cur_op;
    logic [WIDTH:0]   step_wide;
    logic             unsigned_step_ovf;
    logic             signed_step_ovf;
    logic             step_ovf;

    // Handshake decode straight from the state register. Because in_ready is
    // only high in IDLE and out_valid only in DONE, a result handshake and a
    // new accept can never fall on the same edge.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_ready && in_valid;
    assign consume   = out_valid && out_ready;
    assign last_step = (state == ACC) && (idx == LAST_IDX);

    assign sum = acc;
    assign ovf = acc_ovf;

    // One add per cycle: widen by one bit so the unsigned carry is bit WIDTH.
    // Signed overflow is the classic "same-sign addends, different-sign
    // result" rule. Both rules are computed, and the mode latched at accept
    // selects one.
    assign cur_op            = ops[idx];
    assign step_wide         = {1'b0, acc} + {1'b0, cur_op};
    assign unsigned_step_ovf = step_wide[WIDTH];
    assign signed_step_ovf   = (acc[WIDTH-1] == cur_op[WIDTH-1]) &&
                               (step_wide[WIDTH-1] != acc[WIDTH-1]);
    assign step_ovf          = mode_signed ? signed_step_ovf : unsigned_step_ovf;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. ACC always runs for exactly NUM_IN cycles. The exit
    // is taken on the cycle that adds the final operand.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = ACC;
                end
            end
            ACC: begin
                if (idx == LAST_IDX) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand and mode capture. These registers are written only at accept,
    // so in_data and in_signed are free to change during the transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_IN; i++) begin
                ops[i] <= '0;
            end
            mode_signed <= 1'b0;
        end else if (accept) begin
            for (int i = 0; i < NUM_IN; i++) begin
                ops[i] <= in_data[i*WIDTH +: WIDTH];
            end
            mode_signed <= in_signed;
        end
    end

    // Operand index. It is held at the last index when that operand is added,
    // so it never wraps even when NUM_IN is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else if (accept) begin
            idx <= '0;
        end else if ((state == ACC) && !last_step) begin
            idx <= idx + 1'b1;
        end
    end

    // Accumulator and sticky overflow. These registers are cleared at accept
    // and updated only in ACC. That keeps the result stable through DONE,
    // under backpressure, and in IDLE until the next vector is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            acc_ovf <= 1'b0;
        end else if (accept) begin
            acc     <= '0;
            acc_ovf <= 1'b0;
        end else if (state == ACC) begin
            acc     <= step_wide[WIDTH-1:0];
            acc_ovf <= acc_ovf | step_ovf;
        end
    end

    // consume is implied by the DONE -> IDLE transition. It is kept as a
    // named term so the result handshake is easy to find in a waveform.
    logic consume_seen;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            consume_seen <= 1'b0;
        end else begin
            consume_seen <= consume;
        end
    end

    logic unused_ok;
    assign unused_ok = consume_seen;

endmodule

// File: tb/tb_multi_operand_summer.sv
// -----------------------------------------------------------------------------
// tb_multi_operand_summer
//
// Self-checking bench for multi_operand_summer. A 32-bit/8-operand instance
// (dut_a) carries the main sequence. An 8-bit/3-operand instance (dut_b)
// covers the small parameter set. Expected results come either from directed
// constants or from a plain-arithmetic reference model that walks the operand
// list in order.
// -----------------------------------------------------------------------------
module tb_multi_operand_summer;

    localparam int AW = 32;
    localparam int AN = 8;
    localparam int BW = 8;
    localparam int BN = 3;

    logic              clk;
    logic              rst;

    logic              a_in_valid;
    logic              a_in_ready;
    logic [AN*AW-1:0]  a_in_data;
    logic              a_in_signed;
    logic              a_out_valid;
    logic              a_out_ready;
    logic [AW-1:0]     a_sum;
    logic              a_ovf;

    logic              b_in_valid;
    logic              b_in_ready;
    logic [BN*BW-1:0]  b_in_data;
    logic              b_in_signed;
    logic              b_out_valid;
    logic              b_out_ready;
    logic [BW-1:0]     b_sum;
    logic              b_ovf;

    int checks;
    int failures;

    multi_operand_summer #(.WIDTH(AW), .NUM_IN(AN)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .in_signed (a_in_signed),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .sum       (a_sum),
        .ovf       (a_ovf)
    );

    multi_operand_summer #(.WIDTH(BW), .NUM_IN(BN)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_signed (b_in_signed),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .sum       (b_sum),
        .ovf       (b_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: every check in the bench goes through here.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: add operands in index order with exact integer
    // arithmetic. Out-of-range steps are flagged under the selected
    // interpretation, and each step is reduced modulo 2^w.
    function automatic void refModel(input int w, input int n, input logic [255:0] data,
                                     input bit sgn, output logic [31:0] s, output bit o);
        longint mask;
        longint half;
        longint full;
        longint acc;
        longint x;
        longint sa;
        longint sx;
        longint e;
        logic [255:0] sh;
        full = longint'(1) << w;
        half = longint'(1) << (w - 1);
        mask = full - 1;
        acc  = 0;
        o    = 1'b0;
        for (int i = 0; i < n; i++) begin
            sh = data >> (i * w);
            x  = longint'(sh[63:0]) & mask;
            if (sgn) begin
                sa = (acc >= half) ? acc - full : acc;
                sx = (x >= half) ? x - full : x;
                e  = sa + sx;
                if (e >= half || e < -half) o = 1'b1;
            end else begin
                e = acc + x;
                if (e > mask) o = 1'b1;
            end
            acc = e & mask;
        end
        s = acc[31:0];
    endfunction

    // Full transaction on dut_a. The task checks the accept, the exact
    // latency, the result, the requested number of backpressure cycles with
    // ignored in_valid pulses, and the single consume.
    task automatic applyStimulus(input string tag, input logic [AN*AW-1:0] data, input bit sgn,
                                 input int hold, input logic [AW-1:0] exp_sum, input bit exp_ovf);
        int waited;
        waited = 0;
        while (!a_in_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        checkOutput($sformatf("%s_in_ready", tag), 64'(a_in_ready), 64'd1);
        a_in_valid  = 1'b1;
        a_in_data   = data;
        a_in_signed = sgn;
        @(posedge clk); #1;
        a_in_valid  = 1'b0;
        a_in_data   = {8{$urandom()}};
        a_in_signed = 1'($urandom_range(0, 1));
        checkOutput($sformatf("%s_busy", tag), 64'(a_in_ready), 64'd0);
        repeat (AN - 1) @(posedge clk);
        #1;
        checkOutput($sformatf("%s_early", tag), 64'(a_out_valid), 64'd0);
        @(posedge clk); #1;
        checkOutput($sformatf("%s_valid", tag), 64'(a_out_valid), 64'd1);
        checkOutput($sformatf("%s_sum", tag), 64'(a_sum), 64'(exp_sum));
        checkOutput($sformatf("%s_ovf", tag), 64'(a_ovf), 64'(exp_ovf));
        for (int c = 0; c < hold; c++) begin
            a_in_valid = 1'b1;
            a_in_data  = {8{$urandom()}};
            @(posedge clk); #1;
            checkOutput($sformatf("%s_hold_valid%0d", tag, c), 64'(a_out_valid), 64'd1);
            checkOutput($sformatf("%s_hold_sum%0d", tag, c), 64'(a_sum), 64'(exp_sum));
            checkOutput($sformatf("%s_hold_ovf%0d", tag, c), 64'(a_ovf), 64'(exp_ovf));
            checkOutput($sformatf("%s_hold_rdy%0d", tag, c), 64'(a_in_ready), 64'd0);
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        checkOutput($sformatf("%s_consumed", tag), 64'(a_out_valid), 64'd0);
        checkOutput($sformatf("%s_ready_after", tag), 64'(a_in_ready), 64'd1);
        checkOutput($sformatf("%s_idle_sum", tag), 64'(a_sum), 64'(exp_sum));
        @(posedge clk); #1;
        checkOutput($sformatf("%s_single", tag), 64'(a_out_valid), 64'd0);
    endtask

    initial begin
        logic [AN*AW-1:0] data;
        logic [31:0]      ms;
        bit               mo;
        bit               sgn;
        logic [AW-1:0]    val;

        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        a_in_valid  = 1'b0;
        a_in_data   = '0;
        a_in_signed = 1'b0;
        a_out_ready = 1'b0;
        b_in_valid  = 1'b0;
        b_in_data   = '0;
        b_in_signed = 1'b0;
        b_out_ready = 1'b0;

        #12;
        rst = 1'b0;
        @(posedge clk); #1;
        $display("[TB] reset state");
        checkOutput("rst_in_ready", 64'(a_in_ready), 64'd1);
        checkOutput("rst_out_valid", 64'(a_out_valid), 64'd0);
        checkOutput("rst_sum", 64'(a_sum), 64'd0);
        checkOutput("rst_ovf", 64'(a_ovf), 64'd0);
        checkOutput("rst_b_in_ready", 64'(b_in_ready), 64'd1);

        $display("[TB] directed vectors");
        applyStimulus("all2", {8{32'd2}}, 1'b0, 0, 32'd16, 1'b0);
        applyStimulus("ucarry", {192'd0, 32'h0000_0001, 32'hFFFF_FFFF}, 1'b0, 0, 32'h0, 1'b1);
        applyStimulus("sticky_s", {160'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF},
                      1'b1, 0, 32'h7FFF_FFFF, 1'b1);
        applyStimulus("sticky_u", {160'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF},
                      1'b0, 0, 32'h7FFF_FFFF, 1'b1);
        applyStimulus("no_ovf_s", {8{32'hFFFF_FFFF}}, 1'b1, 0, 32'hFFFF_FFF8, 1'b0);

        $display("[TB] backpressure");
        for (int j = 0; j < AN; j++) data[j*AW +: AW] = $urandom();
        sgn = 1'($urandom_range(0, 1));
        refModel(AW, AN, 256'(data), sgn, ms, mo);
        applyStimulus("bp", data, sgn, 5, ms, mo);

        $display("[TB] reset mid-transaction");
        for (int j = 0; j < AN; j++) data[j*AW +: AW] = 32'h1000_0000 | $urandom();
        a_in_valid = 1'b1;
        a_in_data  = data;
        a_in_signed = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_out_valid", 64'(a_out_valid), 64'd0);
        checkOutput("mid_rst_sum", 64'(a_sum), 64'd0);
        checkOutput("mid_rst_ovf", 64'(a_ovf), 64'd0);
        checkOutput("mid_rst_in_ready", 64'(a_in_ready), 64'd1);
        #2;
        rst = 1'b0;
        repeat (AN + 2) @(posedge clk);
        #1;
        checkOutput("mid_rst_dropped", 64'(a_out_valid), 64'd0);
        applyStimulus("after_rst", {8{32'd1}}, 1'b0, 0, 32'd8, 1'b0);

        $display("[TB] random vectors");
        for (int t = 0; t < 8; t++) begin
            for (int j = 0; j < AN; j++) begin
                case ($urandom_range(0, 4))
                    0: val = 32'h0000_0000;
                    1: val = 32'hFFFF_FFFF;
                    2: val = 32'h7FFF_FFFF;
                    3: val = 32'h8000_0000;
                    default: val = $urandom();
                endcase
                data[j*AW +: AW] = val;
            end
            sgn = 1'($urandom_range(0, 1));
            refModel(AW, AN, 256'(data), sgn, ms, mo);
            applyStimulus($sformatf("rnd%0d", t), data, sgn, int'($urandom_range(0, 2)), ms, mo);
        end

        $display("[TB] small parameter set");
        refModel(BW, BN, 256'({8'h01, 8'h80, 8'h80}), 1'b1, ms, mo);
        checkOutput("b_model_sum", 64'(ms), 64'h01);
        checkOutput("b_model_ovf", 64'(mo), 64'd1);
        b_in_valid  = 1'b1;
        b_in_data   = {8'h01, 8'h80, 8'h80};
        b_in_signed = 1'b1;
        @(posedge clk); #1;
        b_in_valid  = 1'b0;
        b_in_data   = 24'($urandom());
        b_in_signed = 1'b0;
        repeat (BN - 1) @(posedge clk);
        #1;
        checkOutput("b_early", 64'(b_out_valid), 64'd0);
        @(posedge clk); #1;
        checkOutput("b_valid", 64'(b_out_valid), 64'd1);
        checkOutput("b_sum", 64'(b_sum), 64'h01);
        checkOutput("b_ovf", 64'(b_ovf), 64'd1);
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_out_ready = 1'b0;
        checkOutput("b_consumed", 64'(b_out_valid), 64'd0);
        checkOutput("b_ready_after", 64'(b_in_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
